// File: rtl/prbs20_rx_checker.sv
// Receive-side PRBS20 checker: self-synchronising XNOR LFSR (taps 20,3) with
// hunt/lock FSM, windowed loss-of-lock detection and saturating counters.
`timescale 1ns/1ps
module prbs20_rx_checker #(
  parameter int unsigned LOCK_CNT    = 32,
  parameter int unsigned WIN         = 64,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rxda,
  input  logic             outstrobe,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [19:0]      sr_q, sr_d;
  logic [4:0]       fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [7:0]       wbits_q, wbits_d;
  logic [7:0]       werr_q, werr_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] bitc_q, bitc_d;
  logic             bit_err_q, bit_err_d;
  logic             lock_lost_q, lock_lost_d;

  logic             exp_bit, mis;
  logic [7:0]       wbits_base, werr_base;

  // Prediction always comes from the pre-shift register contents.
  assign exp_bit = ~(sr_q[2] ^ sr_q[19]);
  assign mis     = rxda ^ exp_bit;

  // NOTE: every variable gets a default before any branch, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    match_d     = match_q;
    wbits_d     = wbits_q;
    werr_d      = werr_q;
    err_d       = err_q;
    bitc_d      = bitc_q;
    bit_err_d   = 1'b0;
    lock_lost_d = 1'b0;
    wbits_base  = wbits_q;
    werr_base   = werr_q;

    if (outstrobe) begin
      // Shift in the received bit, not the predicted one: self-synchronous.
      sr_d = {sr_q[18:0], rxda};
      unique case (state_q)
        HUNT: begin
          if (fill_q != 5'd20) begin
            fill_d = fill_q + 5'd1;
          end else if (mis || (&sr_d)) begin
            // All-ones is the XNOR lock-up state; it must never look like a match.
            match_d = 8'd0;
          end else if (match_q == 8'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            match_d = 8'd0;
            wbits_d = 8'd0;
            werr_d  = 8'd0;
          end else begin
            match_d = match_q + 8'd1;
          end
        end

        LOCKED: begin
          if (bitc_q != CNT_MAX) bitc_d = bitc_q + CNT_W'(1);
          // The bit after the WIN-th one opens a fresh window.
          if (wbits_q == 8'(WIN)) begin
            wbits_base = 8'd0;
            werr_base  = 8'd0;
          end
          wbits_d = wbits_base + 8'd1;
          werr_d  = werr_base + {7'd0, mis};
          if (mis) begin
            bit_err_d = 1'b1;
            if (err_q != CNT_MAX) err_d = err_q + CNT_W'(1);
          end
          if (werr_d == 8'(LOSS_THRESH)) begin
            state_d     = HUNT;
            lock_lost_d = 1'b1;
            match_d     = 8'd0;
          end
        end

        default: state_d = HUNT;
      endcase
    end

    if (clear_cnt) begin
      err_d  = '0;
      bitc_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      wbits_q     <= '0;
      werr_q      <= '0;
      err_q       <= '0;
      bitc_q      <= '0;
      bit_err_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      wbits_q     <= wbits_d;
      werr_q      <= werr_d;
      err_q       <= err_d;
      bitc_q      <= bitc_d;
      bit_err_q   <= bit_err_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign bit_err   = bit_err_q;
  assign lock_lost = lock_lost_q;
  assign err_count = err_q;
  assign bit_count = bitc_q;

endmodule

// File: tb/tb_prbs20_rx_checker.sv
// Directed bench for prbs20_rx_checker: lock, single error, loss/relock,
// stuck-high input, counter saturation/clear and asynchronous reset.
`timescale 1ns/1ps
module tb_prbs20_rx_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        rxda;
  logic        outstrobe;
  logic        clear_cnt;

  logic        locked, bit_err, lock_lost;
  logic [15:0] err_count, bit_count;

  logic        s_locked, s_bit_err, s_lock_lost;
  logic [3:0]  s_err_count, s_bit_count;

  int          errors = 0;
  int          checks = 0;

  logic [19:0] g;       // transmit generator state
  logic [19:0] m_sr;    // bench copy of the receive shift register
  logic        cap_bit_err, cap_lock_lost, cap_s_bit_err;
  int          idle_pulses;

  always #5 clock = ~clock;

  prbs20_rx_checker dut (
    .clock(clock), .reset(reset), .rxda(rxda), .outstrobe(outstrobe),
    .clear_cnt(clear_cnt), .locked(locked), .bit_err(bit_err),
    .lock_lost(lock_lost), .err_count(err_count), .bit_count(bit_count)
  );

  // Narrow counters and a loss threshold equal to the window so errors can pile up.
  prbs20_rx_checker #(.CNT_W(4), .LOSS_THRESH(64)) dut_sat (
    .clock(clock), .reset(reset), .rxda(rxda), .outstrobe(outstrobe),
    .clear_cnt(clear_cnt), .locked(s_locked), .bit_err(s_bit_err),
    .lock_lost(s_lock_lost), .err_count(s_err_count), .bit_count(s_bit_count)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic next_gen(output logic b);
    b = ~(g[2] ^ g[19]);
    g = {g[18:0], b};
  endtask

  task automatic model(input logic b, output logic mis);
    mis  = b ^ ~(m_sr[2] ^ m_sr[19]);
    m_sr = {m_sr[18:0], b};
  endtask

  // Called at a falling edge; one valid bit followed by three idle clocks.
  task automatic send_bit(input logic b, input logic clr);
    rxda      = b;
    outstrobe = 1'b1;
    clear_cnt = clr;
    @(negedge clock);
    outstrobe     = 1'b0;
    clear_cnt     = 1'b0;
    cap_bit_err   = bit_err;
    cap_lock_lost = lock_lost;
    cap_s_bit_err = s_bit_err;
    repeat (3) begin
      @(negedge clock);
      if (bit_err || lock_lost || s_bit_err || s_lock_lost) idle_pulses++;
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    rxda      = 1'b0;
    outstrobe = 1'b0;
    clear_cnt = 1'b0;
    #400;
    @(negedge clock);
    reset       = 1'b1;
    g           = '0;
    m_sr        = '0;
    idle_pulses = 0;
  endtask

  task automatic lock_up();
    logic b, mis;
    for (int i = 0; i < 52; i++) begin
      next_gen(b);
      model(b, mis);
      send_bit(b, 1'b0);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    rxda      = 1'b1;
    outstrobe = 1'b1;
    clear_cnt = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if ({locked, bit_err, lock_lost, err_count, bit_count} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%b/%b/%0d/%0d want all zero",
               locked, bit_err, lock_lost, err_count, bit_count);
    end
    checks++;
    if ({s_locked, s_bit_err, s_lock_lost, s_err_count, s_bit_count} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs_sat: got %b/%b/%b/%0d/%0d want all zero",
               s_locked, s_bit_err, s_lock_lost, s_err_count, s_bit_count);
    end
  endtask

  task automatic test_lock();
    logic b, mis;
    do_reset();
    for (int i = 1; i <= 52; i++) begin
      next_gen(b);
      model(b, mis);
      send_bit(b, 1'b0);
      checks++;
      if (locked !== (i == 52)) begin
        errors++;
        $display("FAIL lock_timing bit %0d: got locked=%b want %b", i, locked, i == 52);
      end
    end
    checks++;
    if (bit_count !== 16'd0) begin
      errors++;
      $display("FAIL lock_bitcount: got %0d want 0", bit_count);
    end
    for (int i = 1; i <= 10; i++) begin
      next_gen(b);
      model(b, mis);
      send_bit(b, 1'b0);
      checks++;
      if (cap_bit_err !== 1'b0) begin
        errors++;
        $display("FAIL lock_clean_biterr bit %0d: got %b want 0", i, cap_bit_err);
      end
    end
    checks++;
    if (err_count !== 16'd0 || bit_count !== 16'd10) begin
      errors++;
      $display("FAIL lock_counts: got err=%0d bits=%0d want err=0 bits=10", err_count, bit_count);
    end
    checks++;
    if (idle_pulses !== 0) begin
      errors++;
      $display("FAIL lock_idle_pulses: got %0d want 0", idle_pulses);
    end
  endtask

  task automatic test_single_error();
    logic b, mis;
    do_reset();
    lock_up();
    for (int i = 1; i <= 30; i++) begin
      next_gen(b);
      if (i == 5) b = ~b;
      send_bit(b, 1'b0);
      checks++;
      if (cap_bit_err !== (i == 5 || i == 8 || i == 25)) begin
        errors++;
        $display("FAIL single_err_pulse bit %0d: got %b want %b",
                 i, cap_bit_err, (i == 5 || i == 8 || i == 25));
      end
    end
    checks++;
    if (err_count !== 16'd3 || bit_count !== 16'd30 || locked !== 1'b1) begin
      errors++;
      $display("FAIL single_err_totals: got err=%0d bits=%0d locked=%b want 3/30/1",
               err_count, bit_count, locked);
    end
  endtask

  task automatic test_loss_of_lock();
    logic b, mis, relocked;
    int nerr, run, lost_at, relock_bit;
    do_reset();
    lock_up();
    nerr    = 0;
    run     = 0;
    lost_at = -1;
    for (int i = 0; i < 64; i++) begin
      b = (i % 2 == 0);
      model(b, mis);
      send_bit(b, 1'b0);
      if (lost_at < 0) begin
        if (mis) nerr++;
        checks++;
        if (cap_lock_lost !== (mis && nerr == 8)) begin
          errors++;
          $display("FAIL loss_pulse bit %0d: got %b want %b", i, cap_lock_lost, (mis && nerr == 8));
        end
        if (mis && nerr == 8) lost_at = i;
      end else begin
        run = (mis || (&m_sr)) ? 0 : run + 1;
        checks++;
        if (cap_lock_lost !== 1'b0 || locked !== 1'b0) begin
          errors++;
          $display("FAIL loss_after bit %0d: got lost=%b locked=%b want 0/0", i, cap_lock_lost, locked);
        end
      end
    end
    checks++;
    if (lost_at < 0 || err_count !== 16'd8) begin
      errors++;
      $display("FAIL loss_summary: got lost_at=%0d err=%0d want lost and err=8", lost_at, err_count);
    end
    relocked   = 1'b0;
    relock_bit = -1;
    for (int i = 1; i <= 60; i++) begin
      next_gen(b);
      model(b, mis);
      send_bit(b, 1'b0);
      if (!relocked) begin
        run = (mis || (&m_sr)) ? 0 : run + 1;
        if (run == 32) begin
          relocked   = 1'b1;
          relock_bit = i;
        end
      end
      checks++;
      if (locked !== relocked) begin
        errors++;
        $display("FAIL relock bit %0d: got locked=%b want %b", i, locked, relocked);
      end
    end
    checks++;
    if (relock_bit < 32 || relock_bit > 52) begin
      errors++;
      $display("FAIL relock_window: got relock at %0d want 32..52", relock_bit);
    end
  endtask

  task automatic test_stuck_high();
    int early;
    do_reset();
    early = 0;
    for (int i = 1; i <= 200; i++) begin
      send_bit(1'b1, 1'b0);
      if (locked !== 1'b0) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL stuck_high_lock: got %0d locked bits want 0", early);
    end
    checks++;
    if (err_count !== 16'd0 || bit_count !== 16'd0) begin
      errors++;
      $display("FAIL stuck_high_counts: got err=%0d bits=%0d want 0/0", err_count, bit_count);
    end
  endtask

  task automatic test_saturation();
    logic b, mis;
    do_reset();
    lock_up();
    for (int i = 1; i <= 20; i++) begin
      b = m_sr[2] ^ m_sr[19];   // inverse of the prediction
      model(b, mis);
      send_bit(b, 1'b0);
    end
    checks++;
    if (s_err_count !== 4'd15 || s_bit_count !== 4'd15 || s_locked !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: got err=%0d bits=%0d locked=%b want 15/15/1",
               s_err_count, s_bit_count, s_locked);
    end
    b = m_sr[2] ^ m_sr[19];
    model(b, mis);
    send_bit(b, 1'b1);
    checks++;
    if (s_err_count !== 4'd0 || s_bit_count !== 4'd0 || cap_s_bit_err !== 1'b1) begin
      errors++;
      $display("FAIL sat_clear: got err=%0d bits=%0d bit_err=%b want 0/0/1",
               s_err_count, s_bit_count, cap_s_bit_err);
    end
    b = m_sr[2] ^ m_sr[19];
    model(b, mis);
    send_bit(b, 1'b0);
    checks++;
    if (s_err_count !== 4'd1 || s_bit_count !== 4'd1) begin
      errors++;
      $display("FAIL sat_after_clear: got err=%0d bits=%0d want 1/1", s_err_count, s_bit_count);
    end
  endtask

  task automatic test_async_reset();
    logic b;
    do_reset();
    lock_up();
    for (int i = 1; i <= 6; i++) begin
      next_gen(b);
      if (i == 2) b = ~b;
      send_bit(b, 1'b0);
    end
    checks++;
    if (locked !== 1'b1 || err_count !== 16'd2 || bit_count !== 16'd6) begin
      errors++;
      $display("FAIL async_pre: got locked=%b err=%0d bits=%0d want 1/2/6", locked, err_count, bit_count);
    end
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || err_count !== 16'd0 || bit_count !== 16'd0) begin
      errors++;
      $display("FAIL async_clear: got locked=%b err=%0d bits=%0d want 0/0/0", locked, err_count, bit_count);
    end
    reset = 1'b1;
    @(negedge clock);
    for (int i = 1; i <= 52; i++) begin
      next_gen(b);
      send_bit(b, 1'b0);
      checks++;
      if (locked !== (i == 52)) begin
        errors++;
        $display("FAIL async_relock bit %0d: got locked=%b want %b", i, locked, i == 52);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_loss_of_lock();
    test_stuck_high();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prbs20_rx_checker.md
Name: prbs20_rx_checker

Overview:
- Receive-side PRBS checker that sits directly downstream of the ring buffer.
- Consumes the ring buffer's serial output (rxda) qualified by outstrobe and self-synchronises a 20-bit LFSR using the same XNOR taps as the transmit generator.
- Declares lock and counts bit errors in hardware, replacing testbench-side compare logic.
- Exposes lock status, an error pulse and saturating counters for bench and system status readout.

Parameters:
- LOCK_CNT, 32: consecutive predicted-bit matches required in HUNT before declaring lock (1..255)
- WIN, 64: length of the loss-of-lock observation window, in valid bits (2..255)
- LOSS_THRESH, 8: mismatches within one window that force loss of lock (1..WIN)
- CNT_W, 16: width of err_count and bit_count

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-low
- rxda  in  1  serial data from ring buffer
- outstrobe  in  1  rxda valid qualifier; bit consumed on rising clock when 1
- clear_cnt  in  1  synchronous clear of err_count and bit_count
- locked  out  1  1 while FSM in LOCKED
- bit_err  out  1  one-cycle pulse per mismatch while LOCKED
- lock_lost  out  1  one-cycle pulse on LOCKED->HUNT transition
- err_count  out  CNT_W  saturating mismatch count (LOCKED only)
- bit_count  out  CNT_W  saturating count of valid bits checked while LOCKED

Behaviour:
- Reset (reset=0, async): state=HUNT; shift reg sr[19:0]=0; fill, match, window and window-error counters=0; locked=0, bit_err=0, lock_lost=0, err_count=0, bit_count=0.
- Reset asserted mid-operation clears everything immediately. The first valid bit after release is treated as bit 0 of a fresh hunt.
- Prediction: exp = sr[2] XNOR sr[19], taken from sr before the shift.
- On each valid bit: mis = rxda ^ exp; sr <= {sr[18:0], rxda}.
- The shift always uses the received bit, never the predicted one, so the checker is self-synchronous. One flipped line bit yields exactly 3 mismatches: at entry, at tap 2 (+3 bits) and at tap 19 (+20 bits).
- No state changes on cycles where outstrobe=0. bit_err and lock_lost are 0 on any cycle without a consumed bit.
- HUNT:
  - fill counts up to 20 and saturates there. Comparisons are ignored until fill==20, i.e. the first 20 bits only load sr.
  - Once filled: a match increments the match counter; a mismatch clears it to 0.
  - A match is not counted if the post-shift sr==all-ones (XNOR lock-up state); the match counter is held at 0 instead.
  - When the match counter reaches LOCK_CNT on a valid edge: state<=LOCKED, locked=1 from that edge. Window counters are cleared.
- LOCKED:
  - Every valid bit: bit_count+1. On mis: bit_err=1 for one cycle, err_count+1, window-error counter+1.
  - The window bit counter counts 1..WIN. On the WIN-th bit, both window counters reset to 0 on the next bit.
  - If the window-error counter reaches LOSS_THRESH (including on the WIN-th bit): state<=HUNT, locked=0, lock_lost=1 for one cycle, match counter=0. fill stays at 20, so hunting resumes immediately without reload.
  - Loss takes priority over the window wrap on the same bit.
- Counters saturate at 2^CNT_W-1; no wrap.
- clear_cnt=1 zeroes err_count and bit_count on that edge. Clear beats a same-cycle increment, so the result is 0.
- clear_cnt does not affect FSM, sr or window state.
- Output latency: all outputs are registered and change on the rising edge that consumes the bit.

Test Plan:
- Error-free lock: reset low 400 ns, then valid bit every 4th clock from the XNOR LFSR seeded at 0 → locked rises on the 52nd valid bit (20 fill + 32 matches); bit_err stays 0; err_count=0.
- Single bit error: after lock, invert 1 bit → bit_err pulses on that bit, +3 and +20 bits later; err_count=3; locked stays 1.
- Loss of lock: after lock, feed 64 bits of alternating 1/0 → lock_lost pulses once when the 8th in-window mismatch is seen, locked=0; restoring the LFSR stream relocks after 32 further matching bits.
- Stuck-high input: after reset, rxda=1 with outstrobe=1 for 200 bits → locked never asserts; err_count=0.
- Counter clear/saturation: with CNT_W=4 under continuous errors → err_count holds at 15. Assert clear_cnt on a mismatch cycle → err_count=0 (not 1), with bit_err still pulsing.
- Async reset mid-lock: drop reset for 1 ns between clock edges → locked, counters and sr clear immediately. After release, relock requires the full 52 valid bits.
